mod_counter: RTL
================

// Module: mod_counter
// PURPOSE
//   Parametrised modulo counter: up/down direction, runtime limit, synchronous load,
//   and wrap or one-shot mode. Generalises the basic enable counter: width and terminal
//   value are independent, and tc is a one-cycle pulse.
//   Used as the event/timeout counter for datapath and controller blocks.
// PARAMETERS
//   WIDTH     4  bit width of count, data and limit
//   PRESCALE  4  enabled cycles per count step; used only with MOD_COUNTER_PRESCALE_EN; >=1
// PORTS
//   clk    in   1      clock; all logic on posedge
//   r      in   1      reset; synchronous, active-high
//   e      in   1      count enable
//   ld     in   1      synchronous load of data
//   up     in   1      direction: 1 = up (terminal = limit), 0 = down (terminal = 0)
//   mode   in   1      0 = wrap, 1 = one-shot (stop at terminal)
//   data   in   WIDTH  load value
//   limit  in   WIDTH  inclusive upper bound of the count range [0, limit]
//   count  out  WIDTH  current count (registered)
//   tc     out  1      terminal-count pulse (registered, one cycle)
//   done   out  1      one-shot finished (level, registered)
// BEHAVIOUR
//   - Reset (r=1 at posedge): count=0, tc=0, done=0, state=RUN. Priority is r > ld > e.
//   - Load (ld=1): count <= (data > limit) ? limit : data; tc=0; done=0; state=RUN.
//     Load works in either state.
//   - States:
//       RUN  = counting.
//       HOLD = one-shot finished; only reachable with mode=1.
//   - RUN with an enabled step (e=1, plus the prescale tick when compiled in):
//       up=1, count >= limit  -> terminal step.
//       up=1, count <  limit  -> count+1.
//       up=0, count == 0      -> terminal step.
//       up=0, count != 0      -> count-1 (also when count > limit after limit was lowered).
//   - Terminal step:
//       mode=0: count wraps to 0 (up) or to limit (down); tc=1 next cycle; state stays RUN.
//       mode=1: count holds (limit or 0); tc=1 next cycle; done=1; state -> HOLD.
//   - tc is 1 only in the cycle after a terminal step; otherwise 0. It is never held.
//   - HOLD: e, up and mode are ignored; count is frozen; done=1; tc=0.
//     HOLD is left only by r or ld.
//   - e=0 in RUN: count holds; tc=0.
//   - Latency: count and tc update 1 cycle after the sampling edge; no combinational in->out path.
//   - Boundary cases:
//       limit=0, mode=0: count stays 0; tc=1 on every enabled cycle.
//       limit=all-ones, up: wrap 2^WIDTH-1 -> 0 without arithmetic overflow.
//       Simultaneous ld and e: ld wins and no step occurs that cycle.
//       r during HOLD or mid-count: reset values apply on the next edge.
//   - Arithmetic is WIDTH bits, unsigned. Comparisons against limit use >= for robustness.
// CONFIGURATION
//   MOD_COUNTER_PRESCALE_EN defined:
//     - A step occurs only on every PRESCALE-th cycle with e=1.
//     - The prescale counter advances only when e=1 and state=RUN.
//     - It clears on r, on ld, and on each tick.
//     - PRESCALE=1 behaves as undefined.
//   MOD_COUNTER_PRESCALE_EN undefined: every RUN cycle with e=1 is a step; the PRESCALE
//     parameter is unused.
// STRUCTURE
//   - Shared package counter_pkg holds:
//       state encodings ST_RUN=1'b0, ST_HOLD=1'b1;
//       mode constants MODE_WRAP=1'b0, MODE_ONESHOT=1'b1;
//       direction constants DIR_DOWN=1'b0, DIR_UP=1'b1.
//   - Sub-module clk_prescaler (only under the macro):
//       ports clk, r, clr, e -> tick; parameter PRESCALE;
//       counter width $clog2(PRESCALE) (minimum 1).
//   - Top level: state register, next-count logic, tc/done registers.
// TESTING
//   1. Reset then wrap count: WIDTH=4, limit=9, up=1, mode=0, e=1 for 12 cycles
//      -> count 0..9,0,1; tc=1 only in the cycle count shows 0 after 9.
//   2. Down wrap: ld with data=2 at limit=5, then up=0, e=1
//      -> count 2,1,0,5,4; tc pulses once, in the cycle count=5.
//   3. One-shot: limit=3, mode=1, from 0
//      -> count 1,2,3 then holds at 3; tc one pulse; done=1.
//      Further e has no effect. ld with data=0 -> done=0, count=0.
//   4. Load clamp and priority:
//      - data=12, limit=7, ld=1, e=1 -> count=7 next cycle, no step.
//      - r=1 together with ld=1 -> count=0.
//   5. Edges: limit=0, mode=0 -> count stays 0, tc=1 every enabled cycle.
//      limit=15, WIDTH=4 -> 15 wraps to 0 with tc=1.
//   6. MOD_COUNTER_PRESCALE_EN, PRESCALE=3, e=1 -> count steps every 3rd cycle.
//      ld mid-interval restarts the 3-cycle interval.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared encodings for the modulo counter: FSM states, counting
//               mode and counting direction.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // FSM state encodings
    localparam logic [0:0] ST_RUN       = 1'b0;
    localparam logic [0:0] ST_HOLD      = 1'b1;

    // Terminal behaviour: wrap around or stop (one-shot)
    localparam logic       MODE_WRAP    = 1'b0;
    localparam logic       MODE_ONESHOT = 1'b1;

    // Counting direction
    localparam logic       DIR_DOWN     = 1'b0;
    localparam logic       DIR_UP       = 1'b1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/clk_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : clk_prescaler
// Description : Enable divider. Produces a tick on every PRESCALE-th cycle
//               with e=1. The tick is combinational from the current divider
//               value and e, so the consumer steps in the same cycle the
//               PRESCALE-th enable is seen. clr restarts the interval.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic r,
    input  logic clr,
    input  logic e,
    output logic tick
);

    localparam int         CW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tick;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("clk_prescaler: PRESCALE must be >= 1");
    end

    assign w_tick = e && (r_cnt == c_LAST);
    assign tick   = w_tick;

    // Divider count: cleared by reset, clear or tick; advances on enable
    always_ff @(posedge clk) begin
        if (r || clr || w_tick) begin
            r_cnt <= '0;
        end else if (e) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : clk_prescaler
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Parametrised modulo counter with up/down direction, runtime
//               inclusive limit, clamped synchronous load and wrap/one-shot
//               terminal behaviour. tc is a one-cycle registered pulse after a
//               terminal step; done is a registered level while in HOLD.
//               Optional macro MOD_COUNTER_PRESCALE_EN: a step occurs only on
//               every PRESCALE-th enabled RUN cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             e,
    input  logic             ld,
    input  logic             up,
    input  logic             mode,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_done;

    logic             w_run_en;
    logic             w_tick;
    logic             w_step;
    logic             w_terminal;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_wrap_val;
    logic [WIDTH-1:0] w_next_val;

    // Enable as seen while counting; HOLD freezes the prescaler too
    assign w_run_en = e && (r_state == ST_RUN);

`ifdef MOD_COUNTER_PRESCALE_EN
    clk_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .r    (r),
        .clr  (ld),
        .e    (w_run_en),
        .tick (w_tick)
    );
`else
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("mod_counter: PRESCALE must be >= 1");
    end
    assign w_tick = 1'b1;
`endif

    // Step qualification, terminal detection and candidate next values
    always_comb begin
        w_step     = w_run_en && w_tick;
        w_terminal = (up == DIR_UP) ? (r_count >= limit) : (r_count == '0);
        w_load_val = (data > limit) ? limit : data;
        w_wrap_val = (up == DIR_UP) ? '0 : limit;
        w_next_val = (up == DIR_UP) ? (r_count + 1'b1) : (r_count - 1'b1);
    end

    // State register, count register and tc/done output registers
    always_ff @(posedge clk) begin
        if (r) begin
            r_state <= ST_RUN;
            r_count <= '0;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else if (ld) begin
            r_state <= ST_RUN;
            r_count <= w_load_val;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else if (r_state == ST_HOLD) begin
            r_tc    <= 1'b0;
            r_done  <= 1'b1;
        end else if (w_step) begin
            if (w_terminal) begin
                r_tc <= 1'b1;
                if (mode == MODE_ONESHOT) begin
                    r_state <= ST_HOLD;
                    r_done  <= 1'b1;
                end else begin
                    r_count <= w_wrap_val;
                end
            end else begin
                r_count <= w_next_val;
                r_tc    <= 1'b0;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign done  = r_done;

endmodule : mod_counter
`default_nettype wire
